// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin sharing of one combinational 64-bit ALU among NREQ
// requesters. A granted request is held on the ALU for WAIT_CYCLES, then the
// ALU result is registered and returned on a valid/ready response channel.
// Optional feature: define ALU_ARBITER_ERROR_EN to report |alu_error on rsp_err_o.
module alu_arbiter #(
    parameter int         NREQ        = 2,
    parameter int         WAIT_CYCLES = 1,
    parameter logic [4:0] NOP_CMD     = 5'h1F
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req_valid_i,
    output logic [NREQ-1:0]      req_ready_o,
    input  logic [5*NREQ-1:0]    req_cmd_i,
    input  logic [7*NREQ-1:0]    req_opm_i,
    input  logic [64*NREQ-1:0]   req_a_i,
    input  logic [64*NREQ-1:0]   req_b_i,
    output logic [NREQ-1:0]      rsp_valid_o,
    input  logic [NREQ-1:0]      rsp_ready_i,
    output logic [63:0]          rsp_out_o,
    output logic [63:0]          rsp_flags_o,
    output logic                 rsp_err_o,
    output logic [4:0]           alu_cmd_o,
    output logic [6:0]           alu_opm_o,
    output logic [63:0]          alu_a_o,
    output logic [63:0]          alu_b_o,
    input  logic [63:0]          alu_out_i,
    input  logic [63:0]          alu_regF_i,
    input  logic [63:0]          alu_error_i
);

    localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   last_grant_q, last_grant_d;
    logic [IDX_W-1:0]   gnt_q, gnt_d;
    logic [4:0]         cmd_q, cmd_d;
    logic [6:0]         opm_q, opm_d;
    logic [63:0]        a_q, a_d;
    logic [63:0]        b_q, b_d;
    logic [3:0]         cnt_q, cnt_d;
    logic [63:0]        out_q, out_d;
    logic [63:0]        flags_q, flags_d;
    logic               err_q, err_d;

    logic               grant_found;
    logic [IDX_W-1:0]   grant_idx;
    logic               err_cap;

`ifdef ALU_ARBITER_ERROR_EN
    assign err_cap = |alu_error_i;
`else
    logic unused_alu_error;
    assign err_cap          = 1'b0;
    assign unused_alu_error = ^alu_error_i;
`endif

    // Requester index 'offs' positions after 'base', wrapping at NREQ.
    function automatic logic [IDX_W-1:0] rr_idx(input logic [IDX_W-1:0] base, input int offs);
        int s;
        s = int'(base) + offs;
        if (s >= NREQ) s = s - NREQ;
        return IDX_W'(s);
    endfunction

    // Round-robin search starting just after the last granted requester.
    always_comb begin
        // NOTE: every variable written here gets a default first so no latch is inferred.
        grant_found = 1'b0;
        grant_idx   = last_grant_q;
        for (int k = 1; k <= NREQ; k++) begin
            if (!grant_found && req_valid_i[rr_idx(last_grant_q, k)]) begin
                grant_found = 1'b1;
                grant_idx   = rr_idx(last_grant_q, k);
            end
        end
    end

    // Next-state and handshake outputs of the IDLE -> EXEC -> RESP sequence.
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        gnt_d        = gnt_q;
        cmd_d        = cmd_q;
        opm_d        = opm_q;
        a_d          = a_q;
        b_d          = b_q;
        cnt_d        = cnt_q;
        out_d        = out_q;
        flags_d      = flags_q;
        err_d        = err_q;
        req_ready_o  = '0;
        rsp_valid_o  = '0;
        unique case (state_q)
            IDLE: begin
                // Ready is only raised for a valid requester, so ready implies acceptance.
                if (grant_found) begin
                    req_ready_o[grant_idx] = 1'b1;
                    gnt_d   = grant_idx;
                    cmd_d   = req_cmd_i[5*grant_idx +: 5];
                    opm_d   = req_opm_i[7*grant_idx +: 7];
                    a_d     = req_a_i[64*grant_idx +: 64];
                    b_d     = req_b_i[64*grant_idx +: 64];
                    cnt_d   = 4'(WAIT_CYCLES);
                    state_d = EXEC;
                end
            end
            EXEC: begin
                if (cnt_q == 4'd1) begin
                    out_d        = alu_out_i;
                    flags_d      = alu_regF_i;
                    err_d        = err_cap;
                    last_grant_d = gnt_q;
                    state_d      = RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RESP: begin
                rsp_valid_o[gnt_q] = 1'b1;
                if (rsp_ready_i[gnt_q]) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers; reset discards any operation in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            last_grant_q <= IDX_W'(NREQ - 1);
            gnt_q        <= '0;
            cmd_q        <= NOP_CMD;
            opm_q        <= '0;
            a_q          <= '0;
            b_q          <= '0;
            cnt_q        <= '0;
            out_q        <= '0;
            flags_q      <= '0;
            err_q        <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            gnt_q        <= gnt_d;
            cmd_q        <= cmd_d;
            opm_q        <= opm_d;
            a_q          <= a_d;
            b_q          <= b_d;
            cnt_q        <= cnt_d;
            out_q        <= out_d;
            flags_q      <= flags_d;
            err_q        <= err_d;
        end
    end

    // Only EXEC may present a real command, so LOADFLAG-style ops never fire spuriously.
    assign alu_cmd_o   = (state_q == EXEC) ? cmd_q : NOP_CMD;
    assign alu_opm_o   = opm_q;
    assign alu_a_o     = a_q;
    assign alu_b_o     = b_q;
    assign rsp_out_o   = out_q;
    assign rsp_flags_o = flags_q;
    assign rsp_err_o   = err_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed vectors for alu_arbiter with hand-computed results.
// Two instances: WAIT_CYCLES=1 for most cases, WAIT_CYCLES=3 for the hold-time case.
module tb_alu_arbiter;

    localparam logic [4:0] NOP   = 5'h1F;
    localparam logic [4:0] OR_C  = 5'h05;
    localparam logic [4:0] INV_C = 5'h08;
`ifdef ALU_ARBITER_ERROR_EN
    localparam logic EXP_ERR = 1'b1;
`else
    localparam logic EXP_ERR = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    logic err_inj;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    // Instance with WAIT_CYCLES=1
    logic [1:0]   req_valid, req_ready, rsp_valid, rsp_ready;
    logic [9:0]   req_cmd;
    logic [13:0]  req_opm;
    logic [127:0] req_a, req_b;
    logic [63:0]  rsp_out, rsp_flags;
    logic         rsp_err;
    logic [4:0]   alu_cmd;
    logic [6:0]   alu_opm;
    logic [63:0]  alu_a, alu_b, alu_out, alu_regF, alu_error;

    // Instance with WAIT_CYCLES=3
    logic [1:0]   req_valid3, req_ready3, rsp_valid3, rsp_ready3;
    logic [9:0]   req_cmd3;
    logic [13:0]  req_opm3;
    logic [127:0] req_a3, req_b3;
    logic [63:0]  rsp_out3, rsp_flags3;
    logic         rsp_err3;
    logic [4:0]   alu_cmd3;
    logic [6:0]   alu_opm3;
    logic [63:0]  alu_a3, alu_b3, alu_out3, alu_regF3, alu_error3;

    // Minimal stand-in for the shared ALU: OR, INV, zero flag in regF[11].
    function automatic logic [63:0] alu_fn(input logic [4:0] c, input logic [63:0] x, input logic [63:0] y);
        case (c)
            OR_C:    return x | y;
            INV_C:   return ~x;
            default: return 64'h0;
        endcase
    endfunction

    assign alu_out    = alu_fn(alu_cmd, alu_a, alu_b);
    assign alu_regF   = {52'h0, (alu_out == 64'h0), 11'h0};
    assign alu_error  = err_inj ? 64'h0000_0100_0000_0000 : 64'h0;
    assign alu_out3   = alu_fn(alu_cmd3, alu_a3, alu_b3);
    assign alu_regF3  = {52'h0, (alu_out3 == 64'h0), 11'h0};
    assign alu_error3 = 64'h0;

    alu_arbiter #(.NREQ(2), .WAIT_CYCLES(1), .NOP_CMD(NOP)) dut (
        .clk(clk), .rst(rst),
        .req_valid_i(req_valid), .req_ready_o(req_ready),
        .req_cmd_i(req_cmd), .req_opm_i(req_opm), .req_a_i(req_a), .req_b_i(req_b),
        .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready),
        .rsp_out_o(rsp_out), .rsp_flags_o(rsp_flags), .rsp_err_o(rsp_err),
        .alu_cmd_o(alu_cmd), .alu_opm_o(alu_opm), .alu_a_o(alu_a), .alu_b_o(alu_b),
        .alu_out_i(alu_out), .alu_regF_i(alu_regF), .alu_error_i(alu_error)
    );

    alu_arbiter #(.NREQ(2), .WAIT_CYCLES(3), .NOP_CMD(NOP)) dut3 (
        .clk(clk), .rst(rst),
        .req_valid_i(req_valid3), .req_ready_o(req_ready3),
        .req_cmd_i(req_cmd3), .req_opm_i(req_opm3), .req_a_i(req_a3), .req_b_i(req_b3),
        .rsp_valid_o(rsp_valid3), .rsp_ready_i(rsp_ready3),
        .rsp_out_o(rsp_out3), .rsp_flags_o(rsp_flags3), .rsp_err_o(rsp_err3),
        .alu_cmd_o(alu_cmd3), .alu_opm_o(alu_opm3), .alu_a_o(alu_a3), .alu_b_o(alu_b3),
        .alu_out_i(alu_out3), .alu_regF_i(alu_regF3), .alu_error_i(alu_error3)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One complete WAIT_CYCLES=1 transaction on the first instance.
    task automatic single_op(input string tag, input int r, input logic [4:0] c,
                             input logic [63:0] x, input logic [63:0] y,
                             input logic [63:0] exp_out, input logic exp_err);
        logic [1:0] onehot;
        onehot = 2'(1 << r);
        @(negedge clk);
        req_cmd[5*r +: 5]  = c;
        req_a[64*r +: 64]  = x;
        req_b[64*r +: 64]  = y;
        req_valid          = onehot;
        #1 check({tag, "_ready"}, 64'(req_ready), 64'(onehot));
        @(negedge clk);
        req_valid = 2'b00;
        #1 check({tag, "_exec_cmd"}, 64'(alu_cmd), 64'(c));
        @(negedge clk);
        #1 check({tag, "_rsp_valid"}, 64'(rsp_valid), 64'(onehot));
        check({tag, "_rsp_out"}, rsp_out, exp_out);
        check({tag, "_rsp_err"}, 64'(rsp_err), 64'(exp_err));
        rsp_ready = onehot;
        @(negedge clk);
        rsp_ready = 2'b00;
        #1 check({tag, "_done"}, 64'(rsp_valid), 64'h0);
    endtask

    initial begin
        int grants;
        int last_c;
        int exp_g;
        int exp_r;

        rst = 1'b1;       err_inj = 1'b0;
        req_valid = '0;   rsp_ready = '0;  req_cmd = '0;  req_opm = '0;  req_a = '0;  req_b = '0;
        req_valid3 = '0;  rsp_ready3 = '0; req_cmd3 = '0; req_opm3 = '0; req_a3 = '0; req_b3 = '0;

        // Reset values
        repeat (2) @(negedge clk);
        check("rst_ready",   64'(req_ready), 64'h0);
        check("rst_rsp_vld", 64'(rsp_valid), 64'h0);
        check("rst_rsp_out", rsp_out, 64'h0);
        check("rst_flags",   rsp_flags, 64'h0);
        check("rst_err",     64'(rsp_err), 64'h0);
        check("rst_alu_cmd", 64'(alu_cmd), 64'(NOP));
        check("rst_alu_a",   alu_a, 64'h0);
        check("rst_alu_b",   alu_b, 64'h0);
        rst = 1'b0;

        // 1: req0 OR, ready same cycle, response two edges after acceptance
        @(negedge clk);
        req_cmd[4:0] = OR_C;  req_opm[6:0] = 7'h11;
        req_a[63:0]  = 64'hF0F0F0;  req_b[63:0] = 64'h0F0F0F;  req_valid = 2'b01;
        #1 check("t1_ready", 64'(req_ready), 64'h1);
        check("t1_idle_cmd", 64'(alu_cmd), 64'(NOP));
        @(negedge clk);
        req_valid = 2'b00;
        #1 check("t1_exec_cmd", 64'(alu_cmd), 64'(OR_C));
        check("t1_exec_opm", 64'(alu_opm), 64'h11);
        check("t1_exec_a",   alu_a, 64'hF0F0F0);
        check("t1_exec_b",   alu_b, 64'h0F0F0F);
        check("t1_no_rsp",   64'(rsp_valid), 64'h0);
        @(negedge clk);
        #1 check("t1_rsp_vld", 64'(rsp_valid), 64'h1);
        check("t1_rsp_out",   rsp_out, 64'hFFFFFF);
        check("t1_rsp_flags", rsp_flags, 64'h0);
        check("t1_resp_cmd",  64'(alu_cmd), 64'(NOP));
        rsp_ready = 2'b01;
        @(negedge clk);
        rsp_ready = 2'b00;
        #1 check("t1_done", 64'(rsp_valid), 64'h0);

        // 3: req1 INV of all-ones; response held while rsp_ready[1] low
        @(negedge clk);
        req_cmd[9:5] = INV_C;  req_a[127:64] = '1;  req_b[127:64] = 64'h0;  req_valid = 2'b10;
        #1 check("t3_ready", 64'(req_ready), 64'h2);
        @(negedge clk);
        req_valid = 2'b01;
        #1 check("t3_busy_ready", 64'(req_ready), 64'h0);
        @(negedge clk);
        rsp_ready = 2'b01;
        for (int i = 0; i < 5; i++) begin
            #1 check("t3_hold_vld", 64'(rsp_valid), 64'h2);
            check("t3_hold_out",   rsp_out, 64'h0);
            check("t3_hold_flags", rsp_flags, 64'h800);
            check("t3_hold_ready", 64'(req_ready), 64'h0);
            check("t3_hold_cmd",   64'(alu_cmd), 64'(NOP));
            @(negedge clk);
        end
        req_valid = 2'b00;
        rsp_ready = 2'b10;
        @(negedge clk);
        rsp_ready = 2'b00;
        #1 check("t3_done", 64'(rsp_valid), 64'h0);

        // 2: both requesters valid, 4 ops each, strict alternation
        @(negedge clk);
        req_cmd = {OR_C, OR_C};
        req_a[63:0] = 64'h1;  req_b[63:0] = 64'h2;  req_a[127:64] = 64'h4;  req_b[127:64] = 64'h8;
        rsp_ready = 2'b11;
        req_valid = 2'b11;
        grants = 0;  last_c = -1;  exp_g = 0;  exp_r = 0;
        for (int c = 0; c < 60 && grants < 8; c++) begin
            #1;
            if (req_ready != 2'b00) begin
                check($sformatf("t2_grant%0d", grants), 64'(req_ready), 64'h1 << exp_g);
                if (last_c >= 0) check("t2_gap", 64'(c - last_c), 64'd3);
                last_c = c;
                grants++;
                exp_g = 1 - exp_g;
            end
            if (rsp_valid != 2'b00) begin
                check("t2_rsp_vld", 64'(rsp_valid), 64'h1 << exp_r);
                check("t2_rsp_out", rsp_out, (exp_r == 0) ? 64'h3 : 64'hC);
                exp_r = 1 - exp_r;
            end
            @(negedge clk);
        end
        req_valid = 2'b00;
        check("t2_count", 64'(grants), 64'd8);
        @(negedge clk);
        #1 check("t2_last_vld", 64'(rsp_valid), 64'h2);
        check("t2_last_out", rsp_out, 64'hC);
        @(negedge clk);
        rsp_ready = 2'b00;
        #1 check("t2_done", 64'(rsp_valid), 64'h0);

        // 4: reset in EXEC discards the op; short-lived valid has no effect
        @(negedge clk);
        req_cmd[4:0] = OR_C;  req_a[63:0] = 64'h5;  req_b[63:0] = 64'hA;  req_valid = 2'b01;
        #1 check("t4_ready", 64'(req_ready), 64'h1);
        @(negedge clk);
        req_valid = 2'b00;
        #1 check("t4_exec_cmd", 64'(alu_cmd), 64'(OR_C));
        rst = 1'b1;
        #1 check("t4_rst_cmd", 64'(alu_cmd), 64'(NOP));
        check("t4_rst_vld", 64'(rsp_valid), 64'h0);
        @(negedge clk);
        rst = 1'b0;
        #1 check("t4_post_vld", 64'(rsp_valid), 64'h0);
        check("t4_post_out", rsp_out, 64'h0);
        @(negedge clk);
        req_valid = 2'b11;
        #1 check("t4_first_gnt", 64'(req_ready), 64'h1);
        req_valid = 2'b00;
        @(negedge clk);
        #1 check("t4_drop_cmd", 64'(alu_cmd), 64'(NOP));
        check("t4_drop_vld", 64'(rsp_valid), 64'h0);
        check("t4_drop_out", rsp_out, 64'h0);
        single_op("t4_new", 0, OR_C, 64'h30, 64'h03, 64'h33, 1'b0);

        // 6: ALU error injection, then a clean op
        err_inj = 1'b1;
        single_op("t6_err", 1, OR_C, 64'h1, 64'h2, 64'h3, EXP_ERR);
        err_inj = 1'b0;
        single_op("t6_clr", 0, OR_C, 64'h40, 64'h04, 64'h44, 1'b0);

        // 5: WAIT_CYCLES=3, operands held three cycles, response at accept+4
        @(negedge clk);
        req_cmd3[4:0] = OR_C;  req_opm3[6:0] = 7'h2A;
        req_a3[63:0]  = 64'h1234;  req_b3[63:0] = 64'h4321;  req_valid3 = 2'b01;
        #1 check("t5_ready", 64'(req_ready3), 64'h1);
        check("t5_idle_cmd", 64'(alu_cmd3), 64'(NOP));
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            req_valid3 = 2'b00;
            #1 check("t5_exec_a", alu_a3, 64'h1234);
            check("t5_exec_b",   alu_b3, 64'h4321);
            check("t5_exec_cmd", 64'(alu_cmd3), 64'(OR_C));
            check("t5_exec_opm", 64'(alu_opm3), 64'h2A);
            check("t5_exec_vld", 64'(rsp_valid3), 64'h0);
        end
        @(negedge clk);
        #1 check("t5_rsp_vld", 64'(rsp_valid3), 64'h1);
        check("t5_rsp_out",   rsp_out3, 64'h5335);
        check("t5_rsp_flags", rsp_flags3, 64'h0);
        check("t5_rsp_err",   64'(rsp_err3), 64'h0);
        check("t5_resp_cmd",  64'(alu_cmd3), 64'(NOP));
        check("t5_resp_a",    alu_a3, 64'h1234);
        rsp_ready3 = 2'b01;
        @(negedge clk);
        rsp_ready3 = 2'b00;
        #1 check("t5_done", 64'(rsp_valid3), 64'h0);
        check("t5_idle_cmd2", 64'(alu_cmd3), 64'(NOP));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
